// File: rtl/fp_issue_ctrl.sv
// fp_issue_ctrl: FP issue sequencer with register scoreboard,
// FP write-port arbitration and fflags accumulation.
module fp_issue_ctrl #(
  parameter int unsigned FLEN = 64,
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            id_valid_i,
  output logic            id_ready_o,
  input  logic            is_fp_instr_i,
  input  logic            fp_load_i,
  input  logic            illegal_insn_i,
  input  logic            use_fp_rs1_i,
  input  logic            use_fp_rs2_i,
  input  logic            use_fp_rs3_i,
  input  logic            use_fp_rd_i,
  input  logic            rf_we_i,
  input  logic [4:0]      rs1_i,
  input  logic [4:0]      rs2_i,
  input  logic [4:0]      rs3_i,
  input  logic [4:0]      rd_i,
  input  logic [2:0]      rm_i,
  input  logic            fp_rm_dynamic_i,
  input  logic [2:0]      frm_csr_i,
  output logic            fpu_in_valid_o,
  input  logic            fpu_in_ready_i,
  output logic [2:0]      fpu_rm_o,
  input  logic            fpu_out_valid_i,
  output logic            fpu_out_ready_o,
  input  logic [FLEN-1:0] fpu_result_i,
  input  logic [4:0]      fpu_status_i,
  input  logic            lsu_fp_rvalid_i,
  input  logic [FLEN-1:0] lsu_fp_rdata_i,
  input  logic            flush_i,
  output logic            fp_wb_we_o,
  output logic [4:0]      fp_wb_addr_o,
  output logic [FLEN-1:0] fp_wb_data_o,
  output logic            int_wb_we_o,
  output logic [4:0]      int_wb_addr_o,
  output logic [XLEN-1:0] int_wb_data_o,
  output logic            int_wb_pending_o,
  output logic            rm_illegal_o,
  output logic [4:0]      fflags_o,
  output logic            fflags_we_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DRAIN
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] busy_q, busy_d;
  logic [31:0] busy_set, busy_clr;
  logic        ld_pending_q, ld_pending_d;
  logic [4:0]  ld_rd_q, ld_rd_d;
  logic [4:0]  op_rd_q, op_rd_d;
  logic        op_int_q, op_int_d;
  logic        op_fpd_q, op_fpd_d;
  logic [2:0]  op_rm_q, op_rm_d;
  logic [4:0]  fflags_q;

  logic [2:0]  rm_res;
  logic        frm_bad;
  logic        rm_bad;
  logic        hazard;
  logic        kind_ill, kind_ld;
  logic        kind_fp, kind_int;
  logic        ld_ret;
  logic        conflict;
  logic        out_hs;
  logic        drop;
  logic        res_wb;
  logic        clr_op;

  always_comb begin
    rm_res   = fp_rm_dynamic_i ? frm_csr_i : rm_i;
    frm_bad  = frm_csr_i[2] & (frm_csr_i[1] | frm_csr_i[0]);
    kind_ill = id_valid_i & illegal_insn_i;
    kind_ld  = id_valid_i & ~illegal_insn_i & fp_load_i;
    kind_fp  = id_valid_i & ~illegal_insn_i & ~fp_load_i
             & is_fp_instr_i;
    kind_int = id_valid_i & ~illegal_insn_i & ~fp_load_i
             & ~is_fp_instr_i;
    // The instruction sitting in ID during ISSUE is the one already
    // latched with a legal rm, so it is not re-judged there.
    rm_bad   = kind_fp & fp_rm_dynamic_i & frm_bad
             & (state_q != S_ISSUE);
    hazard   = (use_fp_rs1_i & busy_q[rs1_i])
             | (use_fp_rs2_i & busy_q[rs2_i])
             | (use_fp_rs3_i & busy_q[rs3_i])
             | (use_fp_rd_i  & busy_q[rd_i]);
    ld_ret   = lsu_fp_rvalid_i & ld_pending_q;
    conflict = ld_ret & (state_q == S_WAIT)
             & ~op_int_q & op_fpd_q;
    fpu_out_ready_o = ((state_q == S_WAIT) | (state_q == S_DRAIN))
                    & ~conflict;
    out_hs   = fpu_out_valid_i & fpu_out_ready_o;
    drop     = flush_i | (state_q == S_DRAIN);
    res_wb   = out_hs & ~drop;
  end

  always_comb begin
    id_ready_o = 1'b0;
    unique case (1'b1)
      kind_ill: id_ready_o = 1'b1;
      kind_ld:  id_ready_o = ~hazard & ~ld_pending_q;
      kind_int: id_ready_o = ~hazard;
      kind_fp:  id_ready_o = rm_bad
                           | ((state_q == S_ISSUE)
                              & fpu_in_ready_i & ~flush_i);
      default:  id_ready_o = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    busy_set     = '0;
    busy_clr     = '0;
    ld_pending_d = ld_pending_q;
    ld_rd_d      = ld_rd_q;
    op_rd_d      = op_rd_q;
    op_int_d     = op_int_q;
    op_fpd_d     = op_fpd_q;
    op_rm_d      = op_rm_q;
    clr_op       = 1'b0;

    if (kind_ld & ~hazard & ~ld_pending_q & ~flush_i) begin
      busy_set[rd_i] = 1'b1;
      ld_pending_d   = 1'b1;
      ld_rd_d        = rd_i;
    end
    if (ld_ret) begin
      busy_clr[ld_rd_q] = 1'b1;
      ld_pending_d      = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (kind_fp & ~hazard & ~rm_bad & ~flush_i) begin
          state_d  = S_ISSUE;
          op_rd_d  = rd_i;
          op_int_d = rf_we_i;
          op_fpd_d = use_fp_rd_i;
          op_rm_d  = rm_res;
          if (use_fp_rd_i) busy_set[rd_i] = 1'b1;
        end
      end
      S_ISSUE: begin
        // A flush coinciding with the handshake still leaves an op
        // inside the FPU, so its result has to be drained.
        if (fpu_in_ready_i) begin
          state_d = flush_i ? S_DRAIN : S_WAIT;
        end else if (flush_i) begin
          state_d = S_IDLE;
          clr_op  = 1'b1;
        end
      end
      S_WAIT: begin
        if (out_hs) begin
          state_d = S_IDLE;
          clr_op  = 1'b1;
        end else if (flush_i) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (out_hs) begin
          state_d = S_IDLE;
          clr_op  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (clr_op & op_fpd_q) busy_clr[op_rd_q] = 1'b1;
    busy_d = (busy_q & ~busy_clr) | busy_set;
  end

  always_comb begin
    fpu_in_valid_o   = (state_q == S_ISSUE);
    fpu_rm_o         = op_rm_q;
    fp_wb_we_o       = 1'b0;
    fp_wb_addr_o     = '0;
    fp_wb_data_o     = '0;
    if (ld_ret) begin
      fp_wb_we_o   = 1'b1;
      fp_wb_addr_o = ld_rd_q;
      fp_wb_data_o = lsu_fp_rdata_i;
    end else if (res_wb & ~op_int_q & op_fpd_q) begin
      fp_wb_we_o   = 1'b1;
      fp_wb_addr_o = op_rd_q;
      fp_wb_data_o = fpu_result_i;
    end
    int_wb_we_o      = res_wb & op_int_q;
    int_wb_addr_o    = op_rd_q;
    int_wb_data_o    = fpu_result_i[XLEN-1:0];
    int_wb_pending_o = op_int_q & (state_q != S_IDLE);
    rm_illegal_o     = rm_bad;
    fflags_we_o      = res_wb;
    fflags_o         = fflags_q | (res_wb ? fpu_status_i : 5'd0);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      busy_q       <= '0;
      ld_pending_q <= 1'b0;
      ld_rd_q      <= '0;
      op_rd_q      <= '0;
      op_int_q     <= 1'b0;
      op_fpd_q     <= 1'b0;
      op_rm_q      <= '0;
      fflags_q     <= '0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      ld_pending_q <= ld_pending_d;
      ld_rd_q      <= ld_rd_d;
      op_rd_q      <= op_rd_d;
      op_int_q     <= op_int_d;
      op_fpd_q     <= op_fpd_d;
      op_rm_q      <= op_rm_d;
      fflags_q     <= fflags_o;
    end
  end

endmodule

// File: tb/tb_fp_issue_ctrl.sv
// tb_fp_issue_ctrl: directed stimulus with a writeback/fflags
// scoreboard popped by an independent output monitor.
module tb_fp_issue_ctrl;
  localparam int FLEN = 64;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic            id_valid, id_ready, is_fp, fp_load, illegal;
  logic            use1, use2, use3, used, rf_we;
  logic [4:0]      rs1, rs2, rs3, rd;
  logic [2:0]      rm, frm;
  logic            rm_dyn;
  logic            in_valid, in_ready;
  logic [2:0]      fpu_rm;
  logic            out_valid, out_ready;
  logic [FLEN-1:0] result;
  logic [4:0]      status;
  logic            lsu_rvalid;
  logic [FLEN-1:0] lsu_rdata;
  logic            flush;
  logic            fp_we, int_we, int_pend, rm_ill, ff_we;
  logic [4:0]      fp_addr, int_addr, fflags;
  logic [FLEN-1:0] fp_data;
  logic [XLEN-1:0] int_data;

  fp_issue_ctrl #(.FLEN(FLEN), .XLEN(XLEN)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .id_valid_i(id_valid), .id_ready_o(id_ready),
    .is_fp_instr_i(is_fp), .fp_load_i(fp_load),
    .illegal_insn_i(illegal),
    .use_fp_rs1_i(use1), .use_fp_rs2_i(use2),
    .use_fp_rs3_i(use3), .use_fp_rd_i(used),
    .rf_we_i(rf_we),
    .rs1_i(rs1), .rs2_i(rs2), .rs3_i(rs3), .rd_i(rd),
    .rm_i(rm), .fp_rm_dynamic_i(rm_dyn), .frm_csr_i(frm),
    .fpu_in_valid_o(in_valid), .fpu_in_ready_i(in_ready),
    .fpu_rm_o(fpu_rm),
    .fpu_out_valid_i(out_valid), .fpu_out_ready_o(out_ready),
    .fpu_result_i(result), .fpu_status_i(status),
    .lsu_fp_rvalid_i(lsu_rvalid), .lsu_fp_rdata_i(lsu_rdata),
    .flush_i(flush),
    .fp_wb_we_o(fp_we), .fp_wb_addr_o(fp_addr),
    .fp_wb_data_o(fp_data),
    .int_wb_we_o(int_we), .int_wb_addr_o(int_addr),
    .int_wb_data_o(int_data),
    .int_wb_pending_o(int_pend),
    .rm_illegal_o(rm_ill),
    .fflags_o(fflags), .fflags_we_o(ff_we)
  );

  typedef struct packed {
    logic [4:0]  addr;
    logic [63:0] data;
  } wb_t;

  wb_t        fp_q[$];
  wb_t        int_q[$];
  logic [4:0] ff_q[$];
  logic       rmi_q[$];
  int         n_chk = 0;
  int         n_fail = 0;
  logic [4:0] acc = '0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic unexp(input string name, input logic [63:0] act);
    n_chk++;
    n_fail++;
    $display("FAIL %s: unexpected output %h, nothing expected",
             name, act);
  endtask

  // Monitor: pops the scoreboard whenever the DUT produces output.
  always @(negedge clk) begin
    if (rst_n) begin
      if (fp_we) begin
        if (fp_q.size() == 0) unexp("fp_wb", {59'd0, fp_addr});
        else begin
          wb_t e;
          e = fp_q.pop_front();
          chk("fp_wb_addr", {59'd0, fp_addr}, {59'd0, e.addr});
          chk("fp_wb_data", fp_data, e.data);
        end
      end
      if (int_we) begin
        if (int_q.size() == 0) unexp("int_wb", {59'd0, int_addr});
        else begin
          wb_t e;
          e = int_q.pop_front();
          chk("int_wb_addr", {59'd0, int_addr}, {59'd0, e.addr});
          chk("int_wb_data", {32'd0, int_data}, e.data);
        end
      end
      if (ff_we) begin
        if (ff_q.size() == 0) unexp("fflags_we", {59'd0, fflags});
        else chk("fflags", {59'd0, fflags}, {59'd0, ff_q.pop_front()});
      end
      if (rm_ill) begin
        if (rmi_q.size() == 0) unexp("rm_illegal", 64'd1);
        else chk("rm_illegal_ready", {63'd0, id_ready},
                 {63'd0, rmi_q.pop_front()});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic clr_id();
    id_valid = 0; is_fp = 0; fp_load = 0; illegal = 0;
    use1 = 0; use2 = 0; use3 = 0; used = 0; rf_we = 0;
    rs1 = 0; rs2 = 0; rs3 = 0; rd = 0;
    rm = 0; rm_dyn = 0;
  endtask

  task automatic set_fp(input logic [4:0] d, input logic [4:0] a,
                        input logic [4:0] b, input logic intd);
    clr_id();
    id_valid = 1; is_fp = 1;
    use1 = 1; rs1 = a;
    use2 = !intd; rs2 = b;
    used = !intd; rf_we = intd; rd = d;
  endtask

  task automatic set_fsw(input logic [4:0] r);
    clr_id();
    id_valid = 1; use2 = 1; rs2 = r;
  endtask

  task automatic set_flw(input logic [4:0] r);
    clr_id();
    id_valid = 1; fp_load = 1; used = 1; rd = r;
  endtask

  task automatic result_now(input logic [63:0] r, input logic [4:0] s);
    out_valid = 1; result = r; status = s;
    ff_q.push_back(acc | s);
    acc = acc | s;
  endtask

  initial begin
    clr_id();
    frm = 0; in_ready = 0; out_valid = 0; result = '0; status = '0;
    lsu_rvalid = 0; lsu_rdata = '0; flush = 0;
    #2 rst_n = 0;
    smp();
    chk("rst_in_valid", {63'd0, in_valid}, 64'd0);
    chk("rst_out_ready", {63'd0, out_ready}, 64'd0);
    chk("rst_fp_we", {63'd0, fp_we}, 64'd0);
    chk("rst_fflags", {59'd0, fflags}, 64'd0);
    chk("rst_pending", {63'd0, int_pend}, 64'd0);
    nxt();
    rst_n = 1;
    nxt();

    // FADD.S f3,f1,f2 with FPU latency 3
    set_fp(5'd3, 5'd1, 5'd2, 1'b0);
    smp();
    chk("fadd_idle_ready", {63'd0, id_ready}, 64'd0);
    chk("fadd_idle_invalid", {63'd0, in_valid}, 64'd0);
    nxt();
    in_ready = 1;
    smp();
    chk("fadd_in_valid", {63'd0, in_valid}, 64'd1);
    chk("fadd_rm", {61'd0, fpu_rm}, 64'd0);
    chk("fadd_hs_ready", {63'd0, id_ready}, 64'd1);
    nxt();
    in_ready = 0;
    set_fsw(5'd3);
    smp();
    chk("busy3_set", {63'd0, id_ready}, 64'd0);
    nxt();
    clr_id();
    nxt();
    result_now(64'h4008_0000_0000_0000, 5'b00001);
    fp_q.push_back('{5'd3, 64'h4008_0000_0000_0000});
    smp();
    chk("fadd_out_ready", {63'd0, out_ready}, 64'd1);
    nxt();
    out_valid = 0;
    set_fsw(5'd3);
    smp();
    chk("busy3_clr", {63'd0, id_ready}, 64'd1);
    nxt();

    // FLW f5 then FMUL.S f6,f5,f1
    set_flw(5'd5);
    smp();
    chk("flw5_ready", {63'd0, id_ready}, 64'd1);
    nxt();
    set_fp(5'd6, 5'd5, 5'd1, 1'b0);
    smp();
    chk("fmul_raw_stall", {63'd0, id_ready}, 64'd0);
    nxt();
    lsu_rvalid = 1; lsu_rdata = 64'h0000_0000_3F80_0000;
    fp_q.push_back('{5'd5, 64'h0000_0000_3F80_0000});
    smp();
    chk("fmul_ret_stall", {63'd0, id_ready}, 64'd0);
    chk("fmul_ret_noissue", {63'd0, in_valid}, 64'd0);
    nxt();
    lsu_rvalid = 0;
    smp();
    chk("fmul_accept_ready", {63'd0, id_ready}, 64'd0);
    nxt();
    in_ready = 1;
    smp();
    chk("fmul_in_valid", {63'd0, in_valid}, 64'd1);
    chk("fmul_hs_ready", {63'd0, id_ready}, 64'd1);
    nxt();
    clr_id(); in_ready = 0;
    result_now(64'h4010_0000_0000_0000, 5'b00100);
    fp_q.push_back('{5'd6, 64'h4010_0000_0000_0000});
    nxt();
    out_valid = 0;

    // FPU result for f7 collides with load return for f9
    set_fp(5'd7, 5'd1, 5'd2, 1'b0);
    nxt();
    in_ready = 1;
    nxt();
    in_ready = 0;
    set_flw(5'd9);
    smp();
    chk("flw9_in_wait", {63'd0, id_ready}, 64'd1);
    nxt();
    clr_id();
    out_valid = 1; result = 64'h7777; status = 5'b10000;
    lsu_rvalid = 1; lsu_rdata = 64'h9999;
    fp_q.push_back('{5'd9, 64'h9999});
    smp();
    chk("conflict_out_ready", {63'd0, out_ready}, 64'd0);
    chk("conflict_wb_addr", {59'd0, fp_addr}, 64'd9);
    nxt();
    lsu_rvalid = 0;
    result_now(64'h7777, 5'b10000);
    fp_q.push_back('{5'd7, 64'h7777});
    smp();
    chk("after_conflict_ready", {63'd0, out_ready}, 64'd1);
    nxt();
    out_valid = 0;

    // Dynamic rm: illegal frm, then legal frm latched for ISSUE
    set_fp(5'd10, 5'd1, 5'd2, 1'b0);
    rm_dyn = 1; frm = 3'b101;
    rmi_q.push_back(1'b1);
    smp();
    chk("rm_bad_noissue", {63'd0, in_valid}, 64'd0);
    nxt();
    set_fsw(5'd10);
    smp();
    chk("busy10_unchanged", {63'd0, id_ready}, 64'd1);
    chk("rm_bad_still_idle", {63'd0, in_valid}, 64'd0);
    nxt();
    set_fp(5'd10, 5'd1, 5'd2, 1'b0);
    rm = 3'b111; rm_dyn = 1; frm = 3'b010;
    nxt();
    in_ready = 1; frm = 3'b001;
    smp();
    chk("rm_dyn_value", {61'd0, fpu_rm}, 64'd2);
    chk("rm_dyn_valid", {63'd0, in_valid}, 64'd1);
    nxt();
    clr_id(); in_ready = 0; frm = 0;
    result_now(64'hAAAA, 5'b00000);
    fp_q.push_back('{5'd10, 64'hAAAA});
    nxt();
    out_valid = 0;

    // FCVT.W.S x4 with a load returning on the result cycle
    set_fp(5'd4, 5'd1, 5'd0, 1'b1);
    nxt();
    in_ready = 1;
    smp();
    chk("fcvt_pending_issue", {63'd0, int_pend}, 64'd1);
    nxt();
    in_ready = 0;
    set_flw(5'd11);
    nxt();
    clr_id();
    result_now(64'hDEAD_BEEF_1234_5678, 5'b01000);
    int_q.push_back('{5'd4, 64'h1234_5678});
    lsu_rvalid = 1; lsu_rdata = 64'hB0B0;
    fp_q.push_back('{5'd11, 64'hB0B0});
    smp();
    chk("int_no_conflict", {63'd0, out_ready}, 64'd1);
    chk("fcvt_pending_res", {63'd0, int_pend}, 64'd1);
    nxt();
    out_valid = 0; lsu_rvalid = 0;
    smp();
    chk("fcvt_pending_done", {63'd0, int_pend}, 64'd0);

    // FCVT.W.S x4 flushed in WAIT
    nxt();
    set_fp(5'd4, 5'd1, 5'd0, 1'b1);
    nxt();
    in_ready = 1;
    nxt();
    clr_id(); in_ready = 0; flush = 1;
    smp();
    chk("flush_wait_pending", {63'd0, int_pend}, 64'd1);
    nxt();
    flush = 0;
    out_valid = 1; result = 64'h5555; status = 5'b11111;
    smp();
    chk("drain_out_ready", {63'd0, out_ready}, 64'd1);
    chk("drain_no_int_we", {63'd0, int_we}, 64'd0);
    chk("drain_no_ff_we", {63'd0, ff_we}, 64'd0);
    nxt();
    out_valid = 0;
    smp();
    chk("drain_pending_fall", {63'd0, int_pend}, 64'd0);
    chk("drain_fflags_kept", {59'd0, fflags}, {59'd0, acc});

    // Flush while waiting for the FPU to accept
    nxt();
    set_fp(5'd12, 5'd1, 5'd2, 1'b0);
    nxt();
    clr_id(); flush = 1;
    smp();
    chk("flush_issue_valid", {63'd0, in_valid}, 64'd1);
    nxt();
    flush = 0;
    set_fsw(5'd12);
    smp();
    chk("flush_issue_dropped", {63'd0, in_valid}, 64'd0);
    chk("busy12_cleared", {63'd0, id_ready}, 64'd1);
    nxt();

    // Reset while in WAIT with busy[3]
    set_fp(5'd3, 5'd1, 5'd2, 1'b0);
    nxt();
    in_ready = 1;
    nxt();
    clr_id(); in_ready = 0;
    nxt();
    rst_n = 0; acc = '0;
    smp();
    chk("mid_rst_in_valid", {63'd0, in_valid}, 64'd0);
    chk("mid_rst_out_ready", {63'd0, out_ready}, 64'd0);
    chk("mid_rst_fflags", {59'd0, fflags}, 64'd0);
    chk("mid_rst_fp_we", {63'd0, fp_we}, 64'd0);
    nxt();
    rst_n = 1;
    nxt();
    out_valid = 1; result = 64'h3333; status = 5'b00010;
    smp();
    chk("post_rst_ignore_rdy", {63'd0, out_ready}, 64'd0);
    chk("post_rst_ignore_we", {63'd0, fp_we}, 64'd0);
    nxt();
    out_valid = 0;
    set_fsw(5'd3);
    smp();
    chk("post_rst_busy3", {63'd0, id_ready}, 64'd1);
    nxt();
    clr_id();
    nxt();

    chk("fp_q_empty", 64'(fp_q.size()), 64'd0);
    chk("int_q_empty", 64'(int_q.size()), 64'd0);
    chk("ff_q_empty", 64'(ff_q.size()), 64'd0);
    chk("rmi_q_empty", 64'(rmi_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_issue_ctrl.md
Name: fp_issue_ctrl

Overview:
- Sequences floating-point work between the FP decoder outputs, the fpnew FPU and the FP/integer register-file write ports.
- Holds an FP register scoreboard (RAW/WAW hazards), keeps at most one FPU operation and one FP load in flight, and resolves dynamic rounding mode.
- Arbitrates the single FP write port between FPU results and FP load returns, and accumulates fflags.

Parameters:
- FLEN, 64, FP register/result width.
- XLEN, 32, integer writeback width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- id_valid_i  in  1  decoded instruction valid in ID
- id_ready_o  out  1  ID may retire instruction this cycle
- is_fp_instr_i  in  1  instruction needs FPU
- fp_load_i  in  1  FLW/FLD
- illegal_insn_i  in  1  decoder illegal flag
- use_fp_rs1_i / use_fp_rs2_i / use_fp_rs3_i / use_fp_rd_i  in  1 each  operand usage
- rf_we_i  in  1  FPU result goes to integer RF
- rs1_i / rs2_i / rs3_i / rd_i  in  5 each  register indices
- rm_i  in  3  instr rounding mode; fp_rm_dynamic_i  in  1
- frm_csr_i  in  3  CSR frm
- fpu_in_valid_o  out  1 / fpu_in_ready_i  in  1  FPU request handshake
- fpu_rm_o  out  3  resolved rounding mode
- fpu_out_valid_i  in  1 / fpu_out_ready_o  out  1  FPU result handshake
- fpu_result_i  in  FLEN; fpu_status_i  in  5
- lsu_fp_rvalid_i  in  1; lsu_fp_rdata_i  in  FLEN  FP load return (cannot be stalled)
- flush_i  in  1  pipeline flush
- fp_wb_we_o  out  1; fp_wb_addr_o  out  5; fp_wb_data_o  out  FLEN
- int_wb_we_o  out  1; int_wb_addr_o  out  5; int_wb_data_o  out  XLEN (fpu_result_i[XLEN-1:0])
- int_wb_pending_o  out  1  FPU op with integer dest in flight
- rm_illegal_o  out  1  one-cycle pulse, dynamic rm with frm in {5,6,7}
- fflags_o  out  5; fflags_we_o  out  1

Behaviour:
- Reset: FSM=IDLE, busy[31:0]=0, ld_pending=0, all valid/we/pulse outputs 0, fflags_o=0, latched rd/dest=0.
- Resolved rm = fp_rm_dynamic_i ? frm_csr_i : rm_i. Dynamic rm with frm_csr_i in {5,6,7} means: rm_illegal_o pulses, id_ready_o=1, nothing issued, no scoreboard change.
- hazard = any used FP source with its busy bit set, or (use_fp_rd_i & busy[rd_i]).
- illegal_insn_i=1: id_ready_o=1 immediately, no side effects.
- Non-FP, non-load instruction (includes FSW/FSD via use_fp_rs2_i): id_ready_o = ~hazard in any state.
- FP load: id_ready_o = ~hazard & ~ld_pending, in any state. On accept, set busy[rd_i], latch ld_rd, set ld_pending.
- Load return (lsu_fp_rvalid_i):
  - Same cycle: fp_wb_we_o=1, addr=ld_rd, clear busy[ld_rd] and ld_pending.
  - Load always wins the write port; fpu_out_ready_o=0 that cycle if the FPU result also targets FP.
- FSM for is_fp_instr_i:
  - IDLE: if id_valid_i & ~hazard & rm legal, go to ISSUE; latch rd and dest type (int if rf_we_i); set busy[rd_i] if use_fp_rd_i. id_ready_o=0 this cycle.
  - IDLE with hazard: stay, id_ready_o=0.
  - ISSUE: fpu_in_valid_o=1 and held with rm stable until fpu_in_ready_i. The handshake cycle gives id_ready_o=1 and goes to WAIT.
  - WAIT: on fpu_out_valid_i & fpu_out_ready_o, write back to fp_wb_* or int_wb_*, clear busy bit, fflags_o |= fpu_status_i, fflags_we_o=1, go to IDLE.
  - FP compute instructions in WAIT stall with id_ready_o=0; a back-to-back op is accepted the cycle after the return, giving 1 bubble.
  - fpu_out_ready_o=1 in WAIT/DRAIN except during a load-return conflict. Integer-dest results never conflict.
- int_wb_pending_o=1 from ISSUE entry through the result cycle when dest is integer.
- flush_i:
  - In ISSUE: drop fpu_in_valid_o next cycle, clear latched busy bit, go to IDLE. The FPU never handshook, so nothing is in flight.
  - In WAIT: go to DRAIN. The result is consumed with no writeback and no fflags, busy is cleared, then IDLE.
  - Outstanding loads are unaffected by flush.
- Simultaneous load return clearing busy[x] and a new instruction reading x: hazard uses the registered busy, so the instruction stalls one cycle. No bypass.
- Reset mid-operation: everything returns to reset values, and any FPU result arriving afterwards is ignored because the FSM is IDLE.

Test Plan:
- FADD.S f3,f1,f2, rm=000, FPU latency 3 → fpu_in_valid_o 1 cycle after id_valid_i; fp_wb_we_o=1 addr=3 on result cycle; busy[3] set then cleared; fflags_we_o=1.
- FLW f5 then FMUL.S f6,f5,f1 → FMUL id_ready_o=0 until cycle after lsu_fp_rvalid_i; then issues with rs1=5.
- FPU result for f7 and load return for f9 in same cycle → fp_wb_addr_o=9, fpu_out_ready_o=0; f7 written next cycle.
- Dynamic rm with frm_csr_i=3'b101 → rm_illegal_o pulse, fpu_in_valid_o stays 0, busy unchanged. With frm_csr_i=3'b010 → fpu_rm_o=010.
- FCVT.W.S x4 with flush_i in WAIT → no int_wb_we_o, no fflags update, FSM back in IDLE, int_wb_pending_o falls after drain.
- rst_ni low while in WAIT with busy[3]=1 → all outputs 0, busy=0; a later fpu_out_valid_i is ignored.
